// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the UART command link.
// UART_PARITY_EN (when defined) switches both directions from 8N1 to 8E1.
package uart_cmd_pkg;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h5A;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'h01;
    localparam logic [7:0] ST_FRM = 8'h02;

    typedef enum logic [1:0] {HUNT, HDR_OK, PAYLOAD, CHECK} parse_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-FF synchroniser, start-bit recheck at half bit, mid-bit sampling.
// UART_PARITY_EN adds an even-parity bit; a parity error is reported like a bad stop bit.
module uart_byte_rx
    import uart_cmd_pkg::*;
#(
    parameter logic [15:0] BPS_CNT = 16'd434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_err
);
    localparam logic [15:0] BIT_LOAD  = BPS_CNT - 16'd1;
    localparam logic [15:0] HALF_LOAD = (BPS_CNT >> 1) - 16'd1;

    logic        sync1_q, sync2_q, sync3_q;
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        fall;
    logic        stop_ok;
`ifdef UART_PARITY_EN
    logic        par_err_q, par_err_d;
`endif

    assign fall    = sync3_q & ~sync2_q;
    assign rx_byte = sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
`ifdef UART_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
`ifdef UART_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

`ifdef UART_PARITY_EN
    assign stop_ok = sync2_q & ~par_err_q;
`else
    assign stop_ok = sync2_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rx_vld    = 1'b0;
        rx_err    = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (sync2_q) begin
                    // start bit gone by half-bit time: a glitch, not a byte
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = BIT_LOAD;
                    bit_d   = 3'd0;
`ifdef UART_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            RX_DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    sh_d  = {sync2_q, sh_q[7:1]};
                    cnt_d = BIT_LOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = RX_PAR;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_PAR: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
`ifdef UART_PARITY_EN
                    par_err_d = sync2_q ^ (^sh_q);
`endif
                    state_d = RX_STOP;
                    cnt_d   = BIT_LOAD;
                end
            end
            RX_STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = RX_IDLE;
                    rx_vld  = stop_ok;
                    rx_err  = ~stop_ok;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_cmd_link.sv
// UART command endpoint: parses A5 | sel | payload | XOR-chk frames and acks each with 5A + status.
// UART_PARITY_EN selects 8E1 on both RX and TX instead of 8N1.
//
// parser state | meaning
// HUNT         | discard bytes until the 0xA5 header
// HDR_OK       | header seen, next byte is {Mod_SEL,Adress}
// PAYLOAD      | collecting DATA_BYTES payload bytes, MSB first
// CHECK        | next byte is compared with the running XOR
//
// tx state     | meaning
// TX_IDLE      | line high, waiting for a pending status
// TX_START     | start bit
// TX_DATA      | 8 data bits, LSB first
// TX_PAR       | even parity bit (parity build only)
// TX_STOP      | stop bit, then the status byte or back to idle
module uart_cmd_link
    import uart_cmd_pkg::*;
#(
    parameter logic [15:0] BPS_CNT      = 16'd434,
    parameter int          DATA_BYTES   = 3,
    parameter int          ADDR_W       = 2,
    parameter int          SEL_W        = 6,
    parameter int          TIMEOUT_CLKS = 20 * 434
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    uart_rxd,
    output logic                    uart_txd,
    output logic [8*DATA_BYTES-1:0] D,
    output logic [ADDR_W-1:0]       Adress,
    output logic [SEL_W-1:0]        Mod_SEL,
    output logic                    TRP,
    output logic                    frame_err,
    output logic                    busy
);
    localparam int              DW       = 8 * DATA_BYTES;
    localparam int              TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [3:0]      LAST_BYTE = 4'(DATA_BYTES - 1);
    localparam logic [15:0]     BIT_LOAD = BPS_CNT - 16'd1;

    logic [7:0] rx_byte;
    logic       rx_vld, rx_err;

    uart_byte_rx #(.BPS_CNT(BPS_CNT)) u_rx (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .rxd     (uart_rxd),
        .rx_byte (rx_byte),
        .rx_vld  (rx_vld),
        .rx_err  (rx_err)
    );

    parse_state_e     pstate_q, pstate_d;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic [7:0]       sel_byte_q, sel_byte_d;
    logic [7:0]       xor_q, xor_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DW-1:0]    d_q, d_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [SEL_W-1:0] mod_sel_q, mod_sel_d;
    logic             trp_q, trp_d;
    logic             ferr_q, ferr_d;
    logic             st_evt;
    logic [7:0]       st_code;

    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       pend_st_q, pend_st_d;
    logic             take;
    tx_state_e        tx_state_q, tx_state_d;
    logic [15:0]      tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       tx_stat_q, tx_stat_d;
    logic             tx_second_q, tx_second_d;
    logic             txd_q, txd_d;
`ifdef UART_PARITY_EN
    logic             tx_par_q, tx_par_d;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pstate_q    <= HUNT;
            shadow_q    <= '0;
            sel_byte_q  <= '0;
            xor_q       <= '0;
            bcnt_q      <= '0;
            tmo_q       <= TMO_LOAD;
            d_q         <= '0;
            adr_q       <= '0;
            mod_sel_q   <= '0;
            trp_q       <= 1'b0;
            ferr_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_st_q   <= ST_OK;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            tx_stat_q   <= ST_OK;
            tx_second_q <= 1'b0;
            txd_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q    <= 1'b0;
`endif
        end else begin
            pstate_q    <= pstate_d;
            shadow_q    <= shadow_d;
            sel_byte_q  <= sel_byte_d;
            xor_q       <= xor_d;
            bcnt_q      <= bcnt_d;
            tmo_q       <= tmo_d;
            d_q         <= d_d;
            adr_q       <= adr_d;
            mod_sel_q   <= mod_sel_d;
            trp_q       <= trp_d;
            ferr_q      <= ferr_d;
            pend_vld_q  <= pend_vld_d;
            pend_st_q   <= pend_st_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_stat_q   <= tx_stat_d;
            tx_second_q <= tx_second_d;
            txd_q       <= txd_d;
`ifdef UART_PARITY_EN
            tx_par_q    <= tx_par_d;
`endif
        end
    end

    always_comb begin
        pstate_d   = pstate_q;
        shadow_d   = shadow_q;
        sel_byte_d = sel_byte_q;
        xor_d      = xor_q;
        bcnt_d     = bcnt_q;
        tmo_d      = tmo_q;
        d_d        = d_q;
        adr_d      = adr_q;
        mod_sel_d  = mod_sel_q;
        trp_d      = 1'b0;
        ferr_d     = 1'b0;
        st_evt     = 1'b0;
        st_code    = ST_OK;

        // a completed byte always beats an expiring timeout
        if (rx_vld || rx_err) begin
            tmo_d = TMO_LOAD;
        end else if (pstate_q != HUNT && tmo_q != '0) begin
            tmo_d = tmo_q - TMO_ONE;
        end

        if (rx_err) begin
            if (pstate_q != HUNT) begin
                pstate_d = HUNT;
                ferr_d   = 1'b1;
                st_evt   = 1'b1;
                st_code  = ST_FRM;
            end
        end else if (rx_vld) begin
            case (pstate_q)
                HUNT: begin
                    if (rx_byte == HDR_BYTE) pstate_d = HDR_OK;
                end
                HDR_OK: begin
                    sel_byte_d = rx_byte;
                    xor_d      = rx_byte;
                    bcnt_d     = 4'd0;
                    pstate_d   = PAYLOAD;
                end
                PAYLOAD: begin
                    shadow_d = DW'({shadow_q, rx_byte});
                    xor_d    = xor_q ^ rx_byte;
                    if (bcnt_q == LAST_BYTE) pstate_d = CHECK;
                    else                     bcnt_d   = bcnt_q + 4'd1;
                end
                CHECK: begin
                    pstate_d = HUNT;
                    st_evt   = 1'b1;
                    if (rx_byte == xor_q) begin
                        d_d       = shadow_q;
                        adr_d     = sel_byte_q[ADDR_W-1:0];
                        mod_sel_d = sel_byte_q[7:ADDR_W];
                        trp_d     = 1'b1;
                        st_code   = ST_OK;
                    end else begin
                        ferr_d  = 1'b1;
                        st_code = ST_CHK;
                    end
                end
                default: pstate_d = HUNT;
            endcase
        end else if (pstate_q != HUNT && tmo_q == '0) begin
            pstate_d = HUNT;
            ferr_d   = 1'b1;
            st_evt   = 1'b1;
            st_code  = ST_FRM;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        tx_stat_d   = tx_stat_q;
        tx_second_d = tx_second_q;
        take        = 1'b0;
        txd_d       = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_d    = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                if (pend_vld_q) begin
                    take        = 1'b1;
                    tx_stat_d   = pend_st_q;
                    tx_sh_d     = ACK_BYTE;
                    tx_second_d = 1'b0;
                    tx_cnt_d    = BIT_LOAD;
                    tx_state_d  = TX_START;
`ifdef UART_PARITY_EN
                    tx_par_d    = ^ACK_BYTE;
`endif
                end
            end
            TX_START: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_cnt_d   = BIT_LOAD;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_cnt_d = BIT_LOAD;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PAR;
`else
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end
            end
            TX_PAR: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_cnt_d   = BIT_LOAD;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (!tx_second_q) begin
                    tx_sh_d     = tx_stat_q;
                    tx_second_d = 1'b1;
                    tx_cnt_d    = BIT_LOAD;
                    tx_state_d  = TX_START;
`ifdef UART_PARITY_EN
                    tx_par_d    = ^tx_stat_q;
`endif
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
            TX_PAR:   txd_d = tx_par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // newest status overwrites an unsent one; a capture and a new event in the same cycle keep the new one pending
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_st_d  = pend_st_q;
        if (st_evt) begin
            pend_vld_d = 1'b1;
            pend_st_d  = st_code;
        end else if (take) begin
            pend_vld_d = 1'b0;
        end
    end

    assign uart_txd  = txd_q;
    assign D         = d_q;
    assign Adress    = adr_q;
    assign Mod_SEL   = mod_sel_q;
    assign TRP       = trp_q;
    assign frame_err = ferr_q;
    assign busy      = (pstate_q != HUNT) || (tx_state_q != TX_IDLE) || pend_vld_q;
endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link: frames driven on uart_rxd, acks decoded from uart_txd.
module tb_uart_cmd_link;
    // shortened bit time keeps the run brief; the glitch stays well under half a bit
    localparam int          BPS_I  = 64;
    localparam logic [15:0] BPS    = 16'd64;
    localparam int          TMO    = 20 * 64;
    localparam int          GLITCH = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        TRP, frame_err, busy;

    uart_cmd_link #(
        .BPS_CNT(BPS), .DATA_BYTES(3), .ADDR_W(2), .SEL_W(6), .TIMEOUT_CLKS(TMO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .D(D), .Adress(Adress), .Mod_SEL(Mod_SEL), .TRP(TRP), .frame_err(frame_err), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int trp_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] ack_q[$];
    logic [7:0] mon_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (TRP)       trp_cnt++;
        if (frame_err) ferr_cnt++;
    end

    initial begin : tx_monitor
        forever begin
            @(negedge sys_clk);
            if (sys_rst && !uart_txd) begin
                repeat (BPS_I / 2) @(negedge sys_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BPS_I) @(negedge sys_clk);
                    mon_b[i] = uart_txd;
                end
`ifdef UART_PARITY_EN
                repeat (BPS_I) @(negedge sys_clk);
`endif
                repeat (BPS_I) @(negedge sys_clk);
                ack_q.push_back(mon_b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (BPS_I) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BPS_I) @(negedge sys_clk);
        end
`ifdef UART_PARITY_EN
        uart_rxd = ^b;
        repeat (BPS_I) @(negedge sys_clk);
`endif
        uart_rxd = stop_bit;
        repeat (BPS_I) @(negedge sys_clk);
        uart_rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        send_byte(b4, 1'b1);
        send_byte(b5, 1'b1);
    endtask

    task automatic expect_ack(input string tag, input logic [7:0] st);
        int waited = 0;
        while (ack_q.size() < 2 && waited < 40 * BPS_I) begin
            @(negedge sys_clk);
            waited++;
        end
        if (ack_q.size() < 2) begin
            check_eq({tag, "_ack_count"}, ack_q.size(), 2);
        end else begin
            check_eq({tag, "_ack_hdr"}, ack_q[0], 8'h5A);
            check_eq({tag, "_ack_status"}, ack_q[1], st);
            void'(ack_q.pop_front());
            void'(ack_q.pop_front());
        end
    endtask

    initial begin : stim
        int t0, f0, waited;

        repeat (3) @(negedge sys_clk);
        check_eq("rst_D", D, 24'h0);
        check_eq("rst_Adress", Adress, 2'b00);
        check_eq("rst_Mod_SEL", Mod_SEL, 6'h00);
        check_eq("rst_TRP", TRP, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_txd", uart_txd, 1'b1);
        sys_rst = 1'b1;
        repeat (BPS_I) @(negedge sys_clk);

        // good frame
        t0 = trp_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 8'h0B, 8'h12, 8'h34, 8'h56, 8'h7B);
        repeat (4) @(negedge sys_clk);
        check_eq("good_D", D, 24'h123456);
        check_eq("good_Adress", Adress, 2'b11);
        check_eq("good_Mod_SEL", Mod_SEL, 6'h02);
        check_eq("good_trp_pulses", trp_cnt - t0, 1);
        check_eq("good_ferr_pulses", ferr_cnt - f0, 0);
        expect_ack("good", 8'h00);

        // partial frame then idle past the timeout
        t0 = trp_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h12, 1'b1);
        check_eq("tmo_busy_mid_frame", busy, 1'b1);
        repeat (TMO / 2) @(negedge sys_clk);
        check_eq("tmo_not_early", ferr_cnt - f0, 0);
        waited = 0;
        while (ferr_cnt == f0 && waited < 3 * TMO) begin
            @(negedge sys_clk);
            waited++;
        end
        check_eq("tmo_ferr_pulses", ferr_cnt - f0, 1);
        check_eq("tmo_trp_pulses", trp_cnt - t0, 0);
        check_eq("tmo_D_hold", D, 24'h123456);
        expect_ack("tmo", 8'h02);

        // following good frame with different content: C4^DE^AD^BE = 09
        t0 = trp_cnt;
        send_frame(8'hA5, 8'hC4, 8'hDE, 8'hAD, 8'hBE, 8'h09);
        repeat (4) @(negedge sys_clk);
        check_eq("good2_D", D, 24'hDEADBE);
        check_eq("good2_Adress", Adress, 2'b00);
        check_eq("good2_Mod_SEL", Mod_SEL, 6'h31);
        check_eq("good2_trp_pulses", trp_cnt - t0, 1);
        expect_ack("good2", 8'h00);

        // checksum mismatch
        t0 = trp_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 8'h0B, 8'h12, 8'h34, 8'h56, 8'h7C);
        repeat (4) @(negedge sys_clk);
        check_eq("chk_D_hold", D, 24'hDEADBE);
        check_eq("chk_Adress_hold", Adress, 2'b00);
        check_eq("chk_Mod_SEL_hold", Mod_SEL, 6'h31);
        check_eq("chk_trp_pulses", trp_cnt - t0, 0);
        check_eq("chk_ferr_pulses", ferr_cnt - f0, 1);
        expect_ack("chk", 8'h01);

        // junk byte and a short low glitch, then a good frame
        t0 = trp_cnt; f0 = ferr_cnt;
        send_byte(8'h00, 1'b1);
        repeat (2 * BPS_I) @(negedge sys_clk);
        uart_rxd = 1'b0;
        repeat (GLITCH) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (3 * BPS_I) @(negedge sys_clk);
        check_eq("noise_no_ack", ack_q.size(), 0);
        check_eq("noise_busy", busy, 1'b0);
        send_frame(8'hA5, 8'h0B, 8'h12, 8'h34, 8'h56, 8'h7B);
        repeat (4) @(negedge sys_clk);
        check_eq("noise_D", D, 24'h123456);
        check_eq("noise_trp_pulses", trp_cnt - t0, 1);
        check_eq("noise_ferr_pulses", ferr_cnt - f0, 0);
        expect_ack("noise", 8'h00);

        // stop bit low on the 3rd byte
        t0 = trp_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (4) @(negedge sys_clk);
        check_eq("stop_ferr_pulses", ferr_cnt - f0, 1);
        check_eq("stop_D_hold", D, 24'h123456);
        check_eq("stop_trp_pulses", trp_cnt - t0, 0);
        expect_ack("stop", 8'h02);

        // reset in the middle of the payload
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0B, 1'b1);
        uart_rxd = 1'b0;
        repeat (3 * BPS_I) @(negedge sys_clk);
        check_eq("rstp_busy_before", busy, 1'b1);
        sys_rst = 1'b0;
        #1;
        check_eq("rstp_D", D, 24'h0);
        check_eq("rstp_Adress", Adress, 2'b00);
        check_eq("rstp_Mod_SEL", Mod_SEL, 6'h00);
        check_eq("rstp_busy", busy, 1'b0);
        check_eq("rstp_txd", uart_txd, 1'b1);
        uart_rxd = 1'b1;
        repeat (2 * BPS_I) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2 * BPS_I) @(negedge sys_clk);

        // reset while an ack is on the wire
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h12, 1'b0);
        waited = 0;
        while (uart_txd && waited < 30 * BPS_I) begin
            @(negedge sys_clk);
            waited++;
        end
        check_eq("rsta_ack_started", uart_txd, 1'b0);
        repeat (BPS_I + BPS_I / 2) @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check_eq("rsta_txd", uart_txd, 1'b1);
        check_eq("rsta_busy", busy, 1'b0);
        check_eq("rsta_TRP", TRP, 1'b0);
        check_eq("rsta_frame_err", frame_err, 1'b0);
        repeat (2 * BPS_I) @(negedge sys_clk);
        check_eq("rsta_txd_held", uart_txd, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
